// File: rtl/pcre_chain_engine.sv
// One-hot/multi-hot NFA for a linear PCRE chain with optional `+` stages and anchoring.
// Optional per-packet completion counter enabled by defining PCRE_CHAIN_MATCH_COUNT_EN.
module pcre_chain_engine #(
    parameter int                  N_STATES  = 11,
    parameter logic [N_STATES-1:0] LOOP_MASK = 11'b00000100000,
    parameter bit                  ANCHORED  = 1'b0,
    parameter int                  OFFSET_W  = 16,
    parameter int                  CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sod,
    input  logic                en,
    input  logic [N_STATES-1:0] char_hit,
    output logic [N_STATES-1:0] state,
    output logic                match,
    output logic                match_pulse,
    output logic [OFFSET_W-1:0] match_offset,
    output logic [OFFSET_W-1:0] byte_cnt
`ifdef PCRE_CHAIN_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]    match_cnt
`endif
);

    if (N_STATES < 2 || N_STATES > 64) begin : g_bad_n_states
        $error("pcre_chain_engine: N_STATES must be in 2..64");
    end
    if (CNT_W < 1 || OFFSET_W < 1) begin : g_bad_width
        $error("pcre_chain_engine: CNT_W and OFFSET_W must be at least 1");
    end

    localparam logic [OFFSET_W-1:0] OFFSET_ONE = {{(OFFSET_W-1){1'b0}}, 1'b1};

    // Byte handshake: en is a valid-only strobe with no back-pressure; every edge
    // with en=1 consumes exactly one byte, whose class hits are on char_hit.
    logic [N_STATES-1:0] cur;
    logic [N_STATES-1:0] nxt;
    logic [OFFSET_W-1:0] idx;
    logic [OFFSET_W-1:0] idx_inc;
    logic                pred0;
    logic                complete;
    logic                match_eff;
    logic                first_hit;

    // sod clears the packet before the same-edge byte is evaluated.
    always_comb begin
        cur       = sod ? '0 : state;
        idx       = sod ? '0 : byte_cnt;
        idx_inc   = (&idx) ? idx : idx + OFFSET_ONE;
        pred0     = ANCHORED ? (idx == '0) : 1'b1;
        nxt       = '0;
        nxt[0]    = char_hit[0] & (pred0 | (LOOP_MASK[0] & cur[0]));
        for (int i = 1; i < N_STATES; i++) begin
            nxt[i] = char_hit[i] & (cur[i-1] | (LOOP_MASK[i] & cur[i]));
        end
        complete  = en & nxt[N_STATES-1];
        match_eff = sod ? 1'b0 : match;
        first_hit = complete & ~match_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= '0;
            match        <= 1'b0;
            match_pulse  <= 1'b0;
            match_offset <= '0;
            byte_cnt     <= '0;
        end else begin
            match_pulse <= first_hit;
            match       <= match_eff | complete;
            if (en) begin
                state    <= nxt;
                byte_cnt <= idx_inc;
            end else begin
                state    <= cur;
                byte_cnt <= idx;
            end
            if (first_hit) begin
                match_offset <= idx;
            end else if (sod) begin
                match_offset <= '0;
            end
        end
    end

`ifdef PCRE_CHAIN_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_eff;

    always_comb begin
        cnt_eff = sod ? '0 : match_cnt;
    end

    // Saturates so a long packet of repeated matches never wraps back to a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (complete && !(&cnt_eff)) begin
            match_cnt <= cnt_eff + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            match_cnt <= cnt_eff;
        end
    end
`endif

endmodule
